pc_sequencer: RTL and testbench

- Sequences the program-counter register of the 5-stage pipelined CPU.
- Each cycle it drives the register's next-address and hold inputs, plus IF/ID and ID/EX pipeline control.
- Resolves load-use stalls, ID-stage jump/branch redirects and a halt/drain sequence.
- Optional performance counters for stalls and flushes.

---
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/IF-ID/ID-EX sequencing for load-use stalls, ID redirects and halt drain; PC_SEQ_PERF_CNT_EN adds stall/flush counters
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          STALL_CYCLES = 1,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  input  logic        id_load_use,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  input  logic        halt_req,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 2);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_o, halt_o, redir, drain;
  assign stall_o = (state_q == RUN && id_load_use) || state_q == STALL;
  assign halt_o  = state_q == RUN && !id_load_use && halt_req;
  assign redir   = state_q == RUN && !id_load_use && !halt_req && (id_jump || id_branch_taken);
  assign drain   = halt_o || state_q == DRAIN || state_q == HALTED;
  // reset forces the PC to RESET_PC and keeps the front of the pipe empty
  assign pc_next     = !rst_n ? RESET_PC :
                       (stall_o || drain) ? pc_cur :
                       redir ? (id_jump ? id_jump_target : id_branch_target) :
                       pc_cur + 32'd4;
  assign pc_hold     = rst_n && (stall_o || drain);
  assign ifid_hold   = rst_n && stall_o;
  assign ifid_flush  = !rst_n || drain || redir;
  assign idex_bubble = !rst_n || stall_o || drain;
  assign halted      = rst_n && state_q == HALTED;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    case (state_q)
      RUN: begin
        state_d = id_load_use ? (STALL_CYCLES > 1 ? STALL : RUN) : halt_req ? DRAIN : RUN;
        cnt_d   = id_load_use ? STALL_INIT : halt_req ? DRAIN_INIT : cnt_q;
      end
      STALL:   state_d = cnt_q == 4'd0 ? RUN : STALL;
      DRAIN:   state_d = cnt_q == 4'd0 ? HALTED : DRAIN;
      default: state_d = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = (stall_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    flush_d = (redir && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of stalls, redirects, halt drain, wrap and counters
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur = 32'h0;
  logic        id_load_use = 1'b0, id_jump = 1'b0, id_branch_taken = 1'b0, halt_req = 1'b0;
  logic [31:0] id_jump_target = 32'h0, id_branch_target = 32'h0;
  logic [31:0] pc_next;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [4:0]  ctl;
  int checks = 0, errors = 0;
`ifdef PC_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [4:0] C_RST = 5'b00110, C_RUN = 5'b00000, C_STL = 5'b11010,
                         C_RED = 5'b00100, C_DRN = 5'b10110, C_HLT = 5'b10111;

  pc_sequencer #(.RESET_PC(32'h0), .STALL_CYCLES(3), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .id_load_use(id_load_use),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .id_branch_taken(id_branch_taken), .id_branch_target(id_branch_target),
    .halt_req(halt_req), .pc_next(pc_next), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, halted};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pc_cur = 32'h1234_5678;
    id_load_use = 1'b1;
    #2;
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_next, 32'h0); end
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
    checks++; if ({stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want %h", {stall_cnt, flush_cnt}, 32'h0); end
    tick();
    id_load_use = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_cur = 32'(i * 4);
      #1;
      checks++; if (pc_next !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_next, 32'(i * 4 + 4)); end
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL seq_ctl[%0d] got %b want %b", i, ctl, C_RUN); end
      tick();
    end
  endtask

  task automatic test_stall();
    pc_cur = 32'h10;
    id_load_use = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_next !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc_next, 32'h10); end
      checks++; if (ctl !== C_STL) begin errors++; $display("FAIL stall_ctl[%0d] got %b want %b", i, ctl, C_STL); end
      tick();
      id_load_use = 1'b0;
      id_branch_taken = 1'b1;
      id_branch_target = 32'h999;
    end
    id_branch_taken = 1'b0;
    #1;
    checks++; if (pc_next !== 32'h14) begin errors++; $display("FAIL stall_exit_pc got %h want %h", pc_next, 32'h14); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL stall_exit_ctl got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, PERF ? 3 : 0); end
    tick();
  endtask

  task automatic test_redirect();
    pc_cur = 32'h20;
    id_branch_taken = 1'b1;
    id_branch_target = 32'h40;
    #1;
    checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL branch_pc got %h want %h", pc_next, 32'h40); end
    checks++; if (ctl !== C_RED) begin errors++; $display("FAIL branch_ctl got %b want %b", ctl, C_RED); end
    tick();
    id_branch_taken = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL branch_after_ctl got %b want %b", ctl, C_RUN); end
    checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL flush_cnt1 got %0d want %0d", flush_cnt, PERF ? 1 : 0); end
    id_branch_taken = 1'b1;
    id_jump = 1'b1;
    id_jump_target = 32'h80;
    #1;
    checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL jump_pc got %h want %h", pc_next, 32'h80); end
    checks++; if (ctl !== C_RED) begin errors++; $display("FAIL jump_ctl got %b want %b", ctl, C_RED); end
    tick();
    id_jump = 1'b0;
    pc_cur = 32'h30;
    #1;
    checks++; if (flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin errors++; $display("FAIL flush_cnt2 got %0d want %0d", flush_cnt, PERF ? 2 : 0); end
    id_load_use = 1'b1;
    #1;
    checks++; if (pc_next !== 32'h30) begin errors++; $display("FAIL lu_br_pc got %h want %h", pc_next, 32'h30); end
    checks++; if (ctl !== C_STL) begin errors++; $display("FAIL lu_br_ctl got %b want %b", ctl, C_STL); end
    tick();
    id_load_use = 1'b0;
    id_branch_taken = 1'b0;
    tick();
    tick();
    checks++; if (flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin errors++; $display("FAIL flush_cnt3 got %0d want %0d", flush_cnt, PERF ? 2 : 0); end
    checks++; if (stall_cnt !== (PERF ? 16'd6 : 16'd0)) begin errors++; $display("FAIL stall_cnt2 got %0d want %0d", stall_cnt, PERF ? 6 : 0); end
  endtask

  task automatic test_wrap();
    pc_cur = 32'hFFFF_FFFC;
    #1;
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", pc_next, 32'h0); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL wrap_ctl got %b want %b", ctl, C_RUN); end
    tick();
  endtask

`ifdef PC_SEQ_PERF_CNT_EN
  task automatic test_saturate();
    force dut.stall_q = 16'hFFFF;
    #1;
    release dut.stall_q;
    id_load_use = 1'b1;
    tick();
    id_load_use = 1'b0;
    tick();
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h want %h", stall_cnt, 16'hFFFF); end
  endtask
`endif

  task automatic test_halt();
    pc_cur = 32'h50;
    halt_req = 1'b1;
    #1;
    checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL halt_ctl got %b want %b", ctl, C_DRN); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      halt_req = 1'b0;
      id_jump = 1'b1;
      id_jump_target = 32'h200;
      #1;
      checks++; if (ctl !== (i == 4 ? C_HLT : C_DRN)) begin errors++; $display("FAIL drain_ctl[%0d] got %b want %b", i, ctl, i == 4 ? C_HLT : C_DRN); end
    end
    id_load_use = 1'b1;
    tick();
    #1;
    checks++; if (ctl !== C_HLT) begin errors++; $display("FAIL halted_stay got %b want %b", ctl, C_HLT); end
    checks++; if ({stall_cnt, flush_cnt} !== (PERF ? {16'hFFFF, 16'd2} : 32'h0)) begin errors++; $display("FAIL halt_cnt got %h want %h", {stall_cnt, flush_cnt}, PERF ? {16'hFFFF, 16'd2} : 32'h0); end
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL async_rst_ctl got %b want %b", ctl, C_RST); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h want %h", pc_next, 32'h0); end
    id_load_use = 1'b0;
    id_jump = 1'b0;
    tick();
    rst_n = 1'b1;
    pc_cur = 32'h100;
    #1;
    checks++; if (pc_next !== 32'h104) begin errors++; $display("FAIL post_rst_pc got %h want %h", pc_next, 32'h104); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL post_rst_ctl got %b want %b", ctl, C_RUN); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef PC_SEQ_PERF_CNT_EN
    test_saturate();
`endif
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
